// File: rtl/roce_bad_frame_filter.sv
// Store-and-forward filter for RoCE TX frames. Each BTH header plus its
// payload is held back until the frame's last beat arrives. A clean frame is
// committed: its beats become visible to the read side and its header is
// queued. A frame that is flagged bad on its last beat, or that does not fit
// in the buffer, is discarded by rewinding the write pointer.
module roce_bad_frame_filter #(
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_FIFO_DEPTH = 512,
  parameter int HDR_FIFO_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    s_roce_bth_valid,
  output logic                    s_roce_bth_ready,
  input  logic [7:0]              s_roce_bth_op_code,
  input  logic [15:0]             s_roce_bth_p_key,
  input  logic [23:0]             s_roce_bth_psn,
  input  logic [23:0]             s_roce_bth_dest_qp,
  input  logic [23:0]             s_roce_bth_src_qp,
  input  logic                    s_roce_bth_ack_req,

  input  logic [DATA_WIDTH-1:0]   s_roce_payload_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_roce_payload_axis_tkeep,
  input  logic                    s_roce_payload_axis_tvalid,
  output logic                    s_roce_payload_axis_tready,
  input  logic                    s_roce_payload_axis_tlast,
  input  logic                    s_roce_payload_axis_tuser,

  output logic                    m_roce_bth_valid,
  input  logic                    m_roce_bth_ready,
  output logic [7:0]              m_roce_bth_op_code,
  output logic [15:0]             m_roce_bth_p_key,
  output logic [23:0]             m_roce_bth_psn,
  output logic [23:0]             m_roce_bth_dest_qp,
  output logic [23:0]             m_roce_bth_src_qp,
  output logic                    m_roce_bth_ack_req,

  output logic [DATA_WIDTH-1:0]   m_roce_payload_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_roce_payload_axis_tkeep,
  output logic                    m_roce_payload_axis_tvalid,
  input  logic                    m_roce_payload_axis_tready,
  output logic                    m_roce_payload_axis_tlast,
  output logic                    m_roce_payload_axis_tuser,

  output logic [31:0]             m_good_count,
  output logic [31:0]             m_drop_count
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int DAW    = $clog2(DATA_FIFO_DEPTH);
  localparam int HAW    = $clog2(HDR_FIFO_DEPTH);
  localparam int BEAT_W = DATA_WIDTH + KEEP_W + 1;
  localparam int HDR_W  = 8 + 16 + 24 + 24 + 24 + 1;

  localparam logic [DAW:0] D_ONE  = (DAW+1)'(1);
  localparam logic [DAW:0] D_FULL = (DAW+1)'(DATA_FIFO_DEPTH - 1);
  localparam logic [HAW:0] H_ONE  = (HAW+1)'(1);
  localparam logic [HAW:0] H_FULL = (HAW+1)'(HDR_FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]        state;
  logic [DAW:0]      wr_ptr, wr_start, commit_ptr, rd_ptr;
  logic [HAW:0]      hdr_wr_ptr, hdr_rd_ptr;
  logic [BEAT_W-1:0] data_mem [DATA_FIFO_DEPTH];
  logic [HDR_W-1:0]  hdr_mem  [HDR_FIFO_DEPTH];
  logic [HDR_W-1:0]  pending_hdr;

  logic [BEAT_W-1:0] beat_p1;
  logic              vld_p1;
  logic [HDR_W-1:0]  hdr_p1;
  logic              hdr_vld_p1;

  logic [DAW:0] data_used;
  logic [HAW:0] hdr_used;
  logic         data_full, hdr_full, hdr_empty, data_avail;
  logic         bth_fire, beat_fire, beat_write, hdr_push;
  logic         data_load, hdr_load;

  // Full is judged against the read pointer so committed-but-unread beats
  // are protected; occupancy never exceeds DATA_FIFO_DEPTH-1.
  assign data_used  = wr_ptr - rd_ptr;
  assign data_full  = (data_used == D_FULL);
  assign hdr_used   = hdr_wr_ptr - hdr_rd_ptr;
  assign hdr_full   = (hdr_used == H_FULL);
  assign hdr_empty  = (hdr_wr_ptr == hdr_rd_ptr);
  assign data_avail = (rd_ptr != commit_ptr);

  assign s_roce_bth_ready           = !rst && (state == ST_IDLE) && !hdr_full;
  assign s_roce_payload_axis_tready = !rst && ((state == ST_FRAME) || (state == ST_DROP));

  assign bth_fire   = s_roce_bth_valid && s_roce_bth_ready;
  assign beat_fire  = s_roce_payload_axis_tvalid && s_roce_payload_axis_tready;
  assign beat_write = beat_fire && (state == ST_FRAME) && !data_full;
  assign hdr_push   = beat_write && s_roce_payload_axis_tlast && !s_roce_payload_axis_tuser;

  // Input FSM: accept a header, then collect its frame and commit or rewind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      wr_start     <= '0;
      commit_ptr   <= '0;
      hdr_wr_ptr   <= '0;
      m_good_count <= '0;
      m_drop_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bth_fire) begin
            wr_start <= wr_ptr;
            state    <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (beat_fire) begin
            if (data_full) begin
              // A beat with no room spoils the whole frame.
              if (s_roce_payload_axis_tlast) begin
                wr_ptr       <= wr_start;
                m_drop_count <= m_drop_count + 32'd1;
                state        <= ST_IDLE;
              end else begin
                state <= ST_DROP;
              end
            end else if (s_roce_payload_axis_tlast) begin
              if (s_roce_payload_axis_tuser) begin
                wr_ptr       <= wr_start;
                m_drop_count <= m_drop_count + 32'd1;
              end else begin
                wr_ptr       <= wr_ptr + D_ONE;
                commit_ptr   <= wr_ptr + D_ONE;
                hdr_wr_ptr   <= hdr_wr_ptr + H_ONE;
                m_good_count <= m_good_count + 32'd1;
              end
              state <= ST_IDLE;
            end else begin
              wr_ptr <= wr_ptr + D_ONE;
            end
          end
        end
        ST_DROP: begin
          if (beat_fire && s_roce_payload_axis_tlast) begin
            wr_ptr       <= wr_start;
            m_drop_count <= m_drop_count + 32'd1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage writes: pending header, payload beats and committed headers.
  always_ff @(posedge clk) begin
    if (bth_fire)
      pending_hdr <= {s_roce_bth_op_code, s_roce_bth_p_key, s_roce_bth_psn,
                      s_roce_bth_dest_qp, s_roce_bth_src_qp, s_roce_bth_ack_req};
    if (beat_write)
      data_mem[wr_ptr[DAW-1:0]] <= {s_roce_payload_axis_tdata, s_roce_payload_axis_tkeep,
                                    s_roce_payload_axis_tlast};
    if (hdr_push)
      hdr_mem[hdr_wr_ptr[HAW-1:0]] <= pending_hdr;
  end

  // ---- payload output register stage ----
  assign data_load = data_avail && (!vld_p1 || m_roce_payload_axis_tready);

  // Payload read side control: advance rd_ptr when the output register refills.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
    end else if (data_load) begin
      rd_ptr <= rd_ptr + D_ONE;
      vld_p1 <= 1'b1;
    end else if (m_roce_payload_axis_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Payload output data, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (data_load)
      beat_p1 <= data_mem[rd_ptr[DAW-1:0]];
  end

  // ---- header output register stage ----
  assign hdr_load = !hdr_empty && (!hdr_vld_p1 || m_roce_bth_ready);

  // Header read side control, independent of the payload side.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_rd_ptr <= '0;
      hdr_vld_p1 <= 1'b0;
    end else if (hdr_load) begin
      hdr_rd_ptr <= hdr_rd_ptr + H_ONE;
      hdr_vld_p1 <= 1'b1;
    end else if (m_roce_bth_ready) begin
      hdr_vld_p1 <= 1'b0;
    end
  end

  // Header output data, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (hdr_load)
      hdr_p1 <= hdr_mem[hdr_rd_ptr[HAW-1:0]];
  end

  assign m_roce_payload_axis_tvalid = vld_p1 && !rst;
  assign {m_roce_payload_axis_tdata, m_roce_payload_axis_tkeep,
          m_roce_payload_axis_tlast} = beat_p1;
  assign m_roce_payload_axis_tuser  = 1'b0;

  assign m_roce_bth_valid = hdr_vld_p1 && !rst;
  assign {m_roce_bth_op_code, m_roce_bth_p_key, m_roce_bth_psn,
          m_roce_bth_dest_qp, m_roce_bth_src_qp, m_roce_bth_ack_req} = hdr_p1;

endmodule
